mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the SoC's single-port synchronous memory among three masters: the debug/program loader (m0), the core load/store unit (m1) and the core instruction fetch (m2). It sits between `riscv` and the memory inside `RISCV_soc`. It issues at most one access per cycle and routes the one-cycle-latency read data back to the owning master. It drives a stall request into the core while fetch is blocked.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `DW/8` byte strobes.
- `MAX_HOLD`, 16, max consecutive m0 grants while m1/m2 wait (starvation guard).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_req`, `m1_req`, `m2_req`  in  1  access request, held until granted.
- `m0_we`, `m1_we`  in  1  write enable; m2 is read-only.
- `m0_addr`, `m1_addr`, `m2_addr`  in  AW  byte address.
- `m0_wdata`, `m1_wdata`  in  DW  write data.
- `m0_wstrb`, `m1_wstrb`  in  DW/8  byte strobes.
- `m0_gnt`, `m1_gnt`, `m2_gnt`  out  1  combinational grant; the access is accepted at this clock edge.
- `m0_rvalid`, `m1_rvalid`, `m2_rvalid`  out  1  read data valid, registered.
- `m0_rdata`, `m1_rdata`, `m2_rdata`  out  DW  read data; `s_rdata` is fanned out, qualified by rvalid.
- `s_en`, `s_we`  out  1  memory enable / write.
- `s_addr`  out  AW;  `s_wdata`  out  DW;  `s_wstrb`  out  DW/8.
- `s_rdata`  in  DW  memory read data, valid one cycle after a read enable.
- `hold_flag_o`  out  1  stall to core: `m2_req & ~m2_gnt`.

## Operation
- At most one `mX_gnt` is high per cycle. `s_en` = OR of grants. The slave signals are muxed from the granted master.
- Priority:
  - m0 wins whenever `m0_req` is high, unless `hold_cnt == MAX_HOLD` and (m1 or m2 requests). In that case m0 loses for that cycle.
  - Between m1 and m2: round-robin. `last` (1 bit) records the last winner among m1/m2; the other master wins a tie.
- `hold_cnt`:
  - Increments (saturating at MAX_HOLD) on each m0 grant while m1 or m2 is requesting.
  - Clears on any m1/m2 grant, or when neither m1 nor m2 requests.
- Read tracking: a 2-bit `owner` register takes the index of the granted master on a granted read; otherwise it takes NONE. The next cycle, `mX_rvalid = (owner == X)`. Writes never produce rvalid.
- Back-to-back: grants can be issued every cycle. Read data for the grant in cycle N appears in cycle N+1, concurrently with the grant of cycle N+1.
- A master must hold req, addr, wdata and we stable until gnt. The arbiter does not latch requests.

## Timing
- Reset values:
  - all rvalid = 0; owner = NONE; `last` = m1 (so m2 wins the first m1/m2 tie); `hold_cnt` = 0.
  - Combinational outputs follow inputs: while `rst` is high, all grants, `s_en` and `s_we` are forced to 0. `hold_flag_o` = `m2_req`.
- Latency: request → grant 0 cycles if uncontended; grant → rvalid exactly 1 cycle.
- Reset asserted with a read outstanding: rvalid is cleared asynchronously and the read data is dropped.
- No request: `s_en` = 0, `s_addr`/`s_wdata` = 0.
- Simultaneous m0/m1/m2 requests with `hold_cnt < MAX_HOLD` → m0 is granted.

## Structure
- Shared package `riscv_defs`: master index constants (`MST_DBG`=0, `MST_LSU`=1, `MST_IFU`=2, `MST_NONE`=3) and the `AW`/`DW` defaults.
- One sub-module: `rr_pick2`, a 2-requester round-robin picker with a `last` register. The remainder (m0 priority, hold counter, owner register, muxes) stays in the top.

## Test plan
- Reset, then m2 alone reads addr 0x0 for 4 consecutive cycles → `m2_gnt` high each cycle; `m2_rvalid` high cycles 1–4 after the first grant; `hold_flag_o` = 0.
- m1 and m2 request continuously → grants alternate m2, m1, m2, m1; `hold_flag_o` = 1 in the m1 cycles.
- m0 writes `0xDEADBEEF` with wstrb=0xF to 0x100, then m1 reads 0x100 → `m1_rvalid` with `m1_rdata` = `0xDEADBEEF`; no rvalid for the write.
- m0 and m2 request continuously, MAX_HOLD=16 → 16 m0 grants, then 1 m2 grant, repeating.
- m2 read granted, `rst` asserted in the next cycle before the clock edge → `m2_rvalid` stays 0; after release, owner = NONE.
- m1 write with wstrb=0x3 → `s_we`=1, `s_wstrb`=0x3, no rvalid on any master.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// riscv_defs: master indices and default bus widths shared by the memory arbiter
package riscv_defs;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    typedef enum logic [1:0] {MST_DBG = 2'd0, MST_LSU = 2'd1, MST_IFU = 2'd2, MST_NONE = 2'd3} mst_e;
endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rr_pick2: two-requester round-robin picker; b wins the first tie after reset
module rr_pick2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);
    logic last_b;
    always_comb begin
        gnt_b = en & req_b & (~req_a | ~last_b);
        gnt_a = en & req_a & ~gnt_b;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_b <= 1'b0;
        else if (gnt_a | gnt_b)
            last_b <= gnt_b;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: three-master arbiter for a single-port one-cycle-latency memory
import riscv_defs::*;

module mem_bus_arbiter #(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m2_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [AW-1:0] m2_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m2_gnt,
    output logic          m0_rvalid,
    output logic          m1_rvalid,
    output logic          m2_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic [DW-1:0] m2_rdata,
    output logic          s_en,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic [DW-1:0] s_rdata,
    output logic          hold_flag_o
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;
    mst_e          owner;
    logic          waiting;
    logic          m0_win;
    assign waiting = m1_req | m2_req;
    assign m0_win  = m0_req & ~((hold_cnt == HW'(MAX_HOLD)) & waiting);
    assign m0_gnt  = ~rst & m0_win;
    rr_pick2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .en    (~rst & ~m0_win),
        .req_a (m1_req),
        .req_b (m2_req),
        .gnt_a (m1_gnt),
        .gnt_b (m2_gnt)
    );
    always_comb begin
        s_en        = m0_gnt | m1_gnt | m2_gnt;
        s_we        = m0_gnt ? m0_we : (m1_gnt & m1_we);
        s_addr      = m0_gnt ? m0_addr : m1_gnt ? m1_addr : m2_gnt ? m2_addr : '0;
        s_wdata     = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : '0;
        s_wstrb     = m0_gnt ? m0_wstrb : m1_gnt ? m1_wstrb : '0;
        hold_flag_o = m2_req & ~m2_gnt;
    end
    assign m0_rvalid = owner == MST_DBG;
    assign m1_rvalid = owner == MST_LSU;
    assign m2_rvalid = owner == MST_IFU;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m2_rdata  = s_rdata;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            owner    <= MST_NONE;
        end else begin
            hold_cnt <= (m1_gnt | m2_gnt | ~waiting) ? '0 :
                        (m0_gnt && hold_cnt != HW'(MAX_HOLD)) ? hold_cnt + HW'(1) : hold_cnt;
            owner    <= (~s_en | s_we) ? MST_NONE : m0_gnt ? MST_DBG : m1_gnt ? MST_LSU : MST_IFU;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized checks of the arbiter against a behavioural model
module tb_mem_bus_arbiter;
    localparam int MH = 16;
    logic        clk, rst;
    logic        m0_req, m1_req, m2_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m2_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m1_gnt, m2_gnt, m0_rvalid, m1_rvalid, m2_rvalid;
    logic [31:0] m0_rdata, m1_rdata, m2_rdata;
    logic        s_en, s_we, hold_flag_o;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;

    int total, bad;
    int hc, lastw, mown, mw;
    logic [31:0] mexp;
    logic [31:0] mm [256];
    logic [31:0] mem [256];
    logic [63:0] cg, crv, chf, cwe, cws, cm1rd, cm2rd;
    logic act [3];

    mem_bus_arbiter #(.AW(32), .DW(32), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m1_req(m1_req), .m2_req(m2_req),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m2_addr(m2_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_wstrb(m0_wstrb), .m1_wstrb(m1_wstrb),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m2_gnt(m2_gnt),
        .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m2_rvalid(m2_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m2_rdata(m2_rdata),
        .s_en(s_en), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Called just after a falling edge with inputs already applied; returns at the next falling edge.
    task automatic tick();
        int w, eo;
        logic waiting, ewe, se, sw;
        logic [31:0] ea, ewd, ard, sa, sd;
        logic [3:0] ews, ss;
        #1;
        waiting = m1_req | m2_req;
        w = -1;
        if (rst) w = -1;
        else if (m0_req && !(hc == MH && waiting)) w = 0;
        else if (m1_req && m2_req) w = (lastw == 1) ? 2 : 1;
        else if (m1_req) w = 1;
        else if (m2_req) w = 2;
        ea  = (w == 0) ? m0_addr : (w == 1) ? m1_addr : (w == 2) ? m2_addr : 32'h0;
        ewd = (w == 0) ? m0_wdata : (w == 1) ? m1_wdata : 32'h0;
        ews = (w == 0) ? m0_wstrb : (w == 1) ? m1_wstrb : 4'h0;
        ewe = (w == 0) ? m0_we : (w == 1) ? m1_we : 1'b0;
        cmp("gnt", 64'({m2_gnt, m1_gnt, m0_gnt}), (w < 0) ? 64'd0 : 64'(1 << w));
        cmp("s_en", 64'(s_en), 64'(w >= 0));
        cmp("s_we", 64'(s_we), 64'(ewe));
        cmp("s_addr", 64'(s_addr), 64'(ea));
        cmp("s_wdata", 64'(s_wdata), 64'(ewd));
        cmp("s_wstrb", 64'(s_wstrb), 64'(ews));
        cmp("hold_flag", 64'(hold_flag_o), 64'(m2_req && w != 2));
        eo = rst ? 3 : mown;
        cmp("rvalid", 64'({m2_rvalid, m1_rvalid, m0_rvalid}), (eo < 3) ? 64'(1 << eo) : 64'd0);
        if (eo < 3) begin
            ard = (eo == 0) ? m0_rdata : (eo == 1) ? m1_rdata : m2_rdata;
            cmp("rdata", 64'(ard), 64'(mexp));
        end
        cg = 64'({m2_gnt, m1_gnt, m0_gnt});
        crv = 64'({m2_rvalid, m1_rvalid, m0_rvalid});
        chf = 64'(hold_flag_o);
        cwe = 64'(s_we);
        cws = 64'(s_wstrb);
        cm1rd = 64'(m1_rdata);
        cm2rd = 64'(m2_rdata);
        mw = w;
        se = s_en; sw = s_we; sa = s_addr; sd = s_wdata; ss = s_wstrb;
        if (rst) begin
            hc = 0; lastw = 1; mown = 3;
        end else begin
            if (w == 1 || w == 2) begin hc = 0; lastw = w; end
            else if (!waiting) hc = 0;
            else if (w == 0 && hc < MH) hc++;
            mown = (w >= 0 && !ewe) ? w : 3;
            if (w >= 0 && !ewe) mexp = mm[ea[9:2]];
            if (w >= 0 && ewe)
                for (int b = 0; b < 4; b++)
                    if (ews[b]) mm[ea[9:2]][8*b +: 8] = ewd[8*b +: 8];
        end
        @(posedge clk);
        if (se) begin
            if (sw) begin
                for (int b = 0; b < 4; b++)
                    if (ss[b]) mem[sa[9:2]][8*b +: 8] = sd[8*b +: 8];
            end else s_rdata = mem[sa[9:2]];
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        rst = 1'b1;
        m0_req = 0; m1_req = 0; m2_req = 0; m0_we = 0; m1_we = 0;
        m0_addr = 0; m1_addr = 0; m2_addr = 0; m0_wdata = 0; m1_wdata = 0;
        m0_wstrb = 0; m1_wstrb = 0; s_rdata = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A0000C3;
            mm[i]  = mem[i];
        end
        hc = 0; lastw = 1; mown = 3; mexp = 0; mw = -1;
        for (int i = 0; i < 3; i++) act[i] = 1'b0;
        @(negedge clk);
        m2_req = 1;
        tick();
        cmp("rst_gnt", cg, 64'd0);
        cmp("rst_hold", chf, 64'd1);
        rst = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            cmp("t1_gnt", cg, 64'b100);
            cmp("t1_hf", chf, 64'd0);
            if (t > 0) cmp("t1_rv", crv, 64'b100);
        end
        m2_req = 0;
        tick();
        cmp("t1_rv_last", crv, 64'b100);
        cmp("t1_rd", cm2rd, 64'h5A0000C3);
        rst = 1; tick(); rst = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h4; m2_req = 1; m2_addr = 32'h8;
        for (int t = 0; t < 4; t++) begin
            tick();
            cmp("t2_gnt", cg, (t % 2 == 0) ? 64'b100 : 64'b010);
            cmp("t2_hf", chf, 64'(t % 2));
        end
        m1_req = 0; m2_req = 0;
        tick();
        m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
        tick();
        cmp("t3_wgnt", cg, 64'b001);
        m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h100;
        tick();
        cmp("t3_rgnt", cg, 64'b010);
        cmp("t3_rv_wr", crv, 64'd0);
        m1_req = 0;
        tick();
        cmp("t3_rv", crv, 64'b010);
        cmp("t3_rd", cm1rd, 64'hDEADBEEF);
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m2_req = 1; m2_addr = 32'h20;
        for (int t = 0; t < 34; t++) begin
            tick();
            cmp("t4_gnt", cg, (t % 17 == 16) ? 64'b100 : 64'b001);
        end
        m0_req = 0; m2_req = 0;
        tick();
        m2_req = 1; m2_addr = 32'h30;
        tick();
        m2_req = 0; rst = 1;
        tick();
        cmp("t5_rv", crv, 64'd0);
        rst = 0;
        tick();
        cmp("t5_rv_after", crv, 64'd0);
        m1_req = 1; m1_we = 1; m1_addr = 32'h40; m1_wdata = 32'h12345678; m1_wstrb = 4'h3;
        tick();
        cmp("t6_we", cwe, 64'd1);
        cmp("t6_strb", cws, 64'h3);
        m1_req = 0;
        tick();
        cmp("t6_rv", crv, 64'd0);
        mw = -1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) if (act[i] && mw == i) act[i] = 1'b0;
            if (!act[0] && (c >= 1500 || $urandom_range(0, 3) == 0)) begin
                act[0] = 1'b1;
                m0_addr = 32'($urandom_range(0, 255)) << 2;
                m0_we = 1'($urandom_range(0, 1));
                m0_wdata = $urandom;
                m0_wstrb = 4'($urandom);
            end
            if (!act[1] && $urandom_range(0, 1) == 0) begin
                act[1] = 1'b1;
                m1_addr = 32'($urandom_range(0, 255)) << 2;
                m1_we = 1'($urandom_range(0, 1));
                m1_wdata = $urandom;
                m1_wstrb = 4'($urandom);
            end
            if (!act[2] && $urandom_range(0, 1) == 0) begin
                act[2] = 1'b1;
                m2_addr = 32'($urandom_range(0, 255)) << 2;
            end
            m0_req = act[0]; m1_req = act[1]; m2_req = act[2];
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 0; m0_req = 0; m1_req = 0; m2_req = 0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
